// File: rtl/fixed_to_bcd_seq_if.sv
// Request/result bundle for the fixed-point to BCD decoder.
// The master side drives start/value_in; the slave side returns busy, valid and the digits.
interface fixed_to_bcd_seq_if #(
  parameter int FRAC_BITS = 6
);
  localparam int W = 10 + FRAC_BITS;

  logic         start;
  logic [W-1:0] value_in;
  logic         busy;
  logic         valid;
  logic         sign;
  logic [3:0]   hundreds;
  logic [3:0]   tens;
  logic [3:0]   units;
  logic [3:0]   tenths;
  logic [3:0]   hundredths;

  modport master (
    output start, value_in,
    input  busy, valid, sign, hundreds, tens, units, tenths, hundredths
  );

  modport slave (
    input  start, value_in,
    output busy, valid, sign, hundreds, tens, units, tenths, hundredths
  );
endinterface

// File: rtl/fixed_to_bcd_seq.sv
// Sequential decoder from signed Q1.9.F to sign plus five BCD digits (ddd.dd).
// Integer part runs through double-dabble; the fraction is split into tenths/hundredths by repeated subtract-10.
module fixed_to_bcd_seq #(
  parameter int FRAC_BITS = 6,
  parameter int ROUND     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fixed_to_bcd_seq_if.slave  cvt
);
  localparam int W  = 10 + FRAC_BITS;
  localparam int PW = FRAC_BITS + 7;

  typedef enum logic [1:0] {IDLE, ABS, CONV, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   value_q, value_d;
  logic [8:0]     int_sh_q, int_sh_d;
  logic [11:0]    bcd_q, bcd_d;
  logic [6:0]     fr_q, fr_d;
  logic [3:0]     tcnt_q, tcnt_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic           sign_q, sign_d;
  logic [3:0]     hundreds_q, hundreds_d;
  logic [3:0]     tens_q, tens_d;
  logic [3:0]     units_q, units_d;
  logic [3:0]     tenths_q, tenths_d;
  logic [3:0]     hundredths_q, hundredths_d;

  logic [W-1:0]   mag_s;
  logic [9:0]     int_s;
  logic [PW-1:0]  rnd_s;
  logic [6:0]     fr_init_s;

  // One double-dabble step: correct nibbles >= 5, then shift in the next binary bit.
  function automatic logic [11:0] dd_step(input logic [11:0] b, input logic bit_in);
    logic [11:0] adj;
    for (int i = 0; i < 3; i++) begin
      adj[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return 12'({adj, bit_in});
  endfunction

  // Magnitude split into integer and scaled hundredths; the most negative word maps to 512.00.
  always_comb begin
    mag_s     = value_q[W-1] ? ({W{1'b0}} - value_q) : value_q;
    int_s     = mag_s[W-1:FRAC_BITS];
    rnd_s     = (ROUND != 0) ? (PW'(1'b1) << (FRAC_BITS - 1)) : {PW{1'b0}};
    fr_init_s = 7'((PW'(mag_s[FRAC_BITS-1:0]) * PW'(7'd100) + rnd_s) >> FRAC_BITS);
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    int_sh_d     = int_sh_q;
    bcd_d        = bcd_q;
    fr_d         = fr_q;
    tcnt_d       = tcnt_q;
    cnt_d        = cnt_q;
    sign_d       = sign_q;
    hundreds_d   = hundreds_q;
    tens_d       = tens_q;
    units_d      = units_q;
    tenths_d     = tenths_q;
    hundredths_d = hundredths_q;

    case (state_q)
      IDLE, DONE: begin
        if (cvt.start) begin
          state_d = ABS;
          value_d = cvt.value_in;
        end else begin
          state_d = IDLE;
        end
      end
      ABS: begin
        // The int MSB is shifted in here so that nine CONV steps cover all ten bits.
        bcd_d    = {11'd0, int_s[9]};
        int_sh_d = int_s[8:0];
        fr_d     = fr_init_s;
        tcnt_d   = 4'd0;
        cnt_d    = 4'd0;
        state_d  = CONV;
      end
      CONV: begin
        bcd_d    = dd_step(bcd_q, int_sh_q[8]);
        int_sh_d = {int_sh_q[7:0], 1'b0};
        if (fr_q >= 7'd10) begin
          fr_d   = fr_q - 7'd10;
          tcnt_d = tcnt_q + 4'd1;
        end else begin
          fr_d   = fr_q;
          tcnt_d = tcnt_q;
        end
        if (cnt_q == 4'd8) begin
          state_d      = DONE;
          sign_d       = value_q[W-1];
          hundreds_d   = bcd_d[11:8];
          tens_d       = bcd_d[7:4];
          units_d      = bcd_d[3:0];
          tenths_d     = tcnt_d;
          hundredths_d = fr_d[3:0];
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == ABS) || (state_d == CONV);
    valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      value_q      <= {W{1'b0}};
      int_sh_q     <= 9'd0;
      bcd_q        <= 12'd0;
      fr_q         <= 7'd0;
      tcnt_q       <= 4'd0;
      cnt_q        <= 4'd0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      sign_q       <= 1'b0;
      hundreds_q   <= 4'd0;
      tens_q       <= 4'd0;
      units_q      <= 4'd0;
      tenths_q     <= 4'd0;
      hundredths_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      int_sh_q     <= int_sh_d;
      bcd_q        <= bcd_d;
      fr_q         <= fr_d;
      tcnt_q       <= tcnt_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      sign_q       <= sign_d;
      hundreds_q   <= hundreds_d;
      tens_q       <= tens_d;
      units_q      <= units_d;
      tenths_q     <= tenths_d;
      hundredths_q <= hundredths_d;
    end
  end

  assign cvt.busy       = busy_q;
  assign cvt.valid      = valid_q;
  assign cvt.sign       = sign_q;
  assign cvt.hundreds   = hundreds_q;
  assign cvt.tens       = tens_q;
  assign cvt.units      = units_q;
  assign cvt.tenths     = tenths_q;
  assign cvt.hundredths = hundredths_q;
endmodule
